bm_sequencer: RTL
=================

# bm_sequencer

Controller that sequences the branch-metric unit of the radix-4 Viterbi decoder. It first sweeps every (state, input) pair and presents the expected encoder codeword, so the branch-metric unit fills its precomputed distance table. It then streams received 6-bit sliced symbols to the branch-metric/ACS path under a valid/ready handshake, counts the frame, and signals completion. It sits between the symbol slicer (upstream) and the branch-metric unit plus ACS (downstream).

## Interface
Parameters:
- STATE_W, 8, encoder state bits (256 states)
- IN_W, 2, input bits per trellis step (radix 4)
- SYM_W, 6, sliced symbol / codeword bits
- LEN_W, 16, frame-length counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse; ignored unless in IDLE
- i_skip_pre  in  1  sampled with i_start; 1 = reuse the existing table and skip PRECALC
- i_gen  in  60  six 10-bit generator polynomials; poly k = i_gen[10k+9:10k]; latched on accepted start
- i_frame_len  in  LEN_W  symbols per frame; latched on accepted start
- i_sym_valid  in  1  upstream symbol valid
- i_sym  in  SYM_W  upstream sliced symbol
- o_sym_ready  out  1  upstream ready
- o_mux  out  16  table-write address/data to the BM unit: [15:14] input, [13:6] state, [5:0] expected codeword
- o_en_bm  out  1  BM unit enable
- o_rx  out  SYM_W  symbol to the BM unit
- o_rx_valid  out  1  o_rx valid for ACS
- i_acs_ready  in  1  ACS accepts o_rx this cycle
- o_busy  out  1  not IDLE
- o_pre_done  out  1  level; table valid since the last completed PRECALC
- o_frame_done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, PRECALC, SETTLE, DECODE, DONE.
- IDLE: on i_start, latch i_gen and i_frame_len. If i_skip_pre = 1 and o_pre_done = 1, go to SETTLE; otherwise clear o_pre_done and go to PRECALC.
- PRECALC: a 10-bit counter idx runs 0..1023; state = idx[7:0], input = idx[9:8].
- Codeword bit k = XOR-reduce(poly_k & {input, state}). o_mux is registered and presents entry idx in cycle idx.
- After entry 1023 is presented, set o_pre_done and go to SETTLE. On leaving PRECALC, o_mux holds entry 1023, so later BM writes only rewrite the same value.
- SETTLE: one cycle, so the BM table read path reflects the last write. Then go to DECODE, or to DONE if the latched frame length is 0.
- DECODE:
  - o_sym_ready = !o_rx_valid || i_acs_ready.
  - A transfer occurs when i_sym_valid && o_sym_ready. On a transfer, o_rx <= i_sym, o_rx_valid <= 1, and the accepted-symbol counter increments.
  - o_rx_valid clears when i_acs_ready is high and no new transfer occurs.
  - Once frame_len symbols have been accepted, o_sym_ready = 0. Go to DONE when the last symbol is consumed (o_rx_valid && i_acs_ready).
- DONE: o_frame_done = 1 for one cycle, then IDLE.
- o_en_bm = 1 in PRECALC, SETTLE and DECODE; 0 otherwise.
- o_busy = (state != IDLE).

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0, o_pre_done 0.
- Reset asserted mid-operation aborts immediately and the table is treated as invalid.
- Start to first table entry: start accepted at edge N; o_mux shows entry 0 and o_en_bm = 1 in cycle N+1.
- PRECALC lasts exactly 1024 cycles and SETTLE 1 cycle. First o_sym_ready = 1 in cycle N+1026 (N+2 when skipping PRECALC).
- Symbol latency: i_sym to o_rx is 1 cycle. Throughput is 1 symbol/cycle while i_acs_ready = 1.
- Backpressure: when i_acs_ready = 0, o_rx and o_rx_valid hold stable.
- A simultaneous consume and accept in one cycle is a legal transfer; o_rx_valid stays 1.
- Frame counter is LEN_W bits with no wrap; frame_len = 2^LEN_W − 1 is legal.

## Structure
- Package bm_seq_pkg holds:
  - enum bm_seq_state_t {IDLE, PRECALC, SETTLE, DECODE, DONE}
  - constants STATE_W, IN_W, SYM_W, NUM_GEN = 6, GEN_W = 10, TABLE_ENTRIES = 1024
- Sub-module bm_codeword_gen: combinational; takes (gen, state, input) and returns the 6-bit codeword. It is reused by the verification reference model.

## Test plan
- Reset, then start with i_gen = 0 and i_skip_pre = 0 → 1024 cycles with o_mux[5:0] = 0 and o_mux[15:6] counting 0..1023; o_pre_done rises after entry 1023.
- Gen poly0 = 10'h001, poly5 = 10'h300, others 0 → entry state = 8'h05, input = 2'b10 gives codeword 6'b100001.
- frame_len = 4, i_acs_ready = 1, continuous valid symbols 6'h0B, 6'h15, 6'h2A, 6'h3F → o_rx matches with 1-cycle latency; o_sym_ready drops after the 4th symbol; o_frame_done pulses exactly once; FSM back in IDLE.
- Same stream with i_acs_ready low for 3 cycles mid-frame → o_rx held stable, no symbol lost or duplicated, count correct.
- Second start with i_skip_pre = 1 → first o_sym_ready 2 cycles after start; o_mux unchanged.
- rst asserted during PRECALC at idx = 500, then a start with i_skip_pre = 1 → full PRECALC executes, because o_pre_done was cleared.

Source files
------------

// File: rtl/bm_seq_pkg.sv
// bm_seq_pkg: shared types and constants for the branch-metric sequencer.
//   bm_seq_state_t - sequencer FSM states (encoding also exposed on dbg_state)
//   NUM_GEN/GEN_W  - six 10-bit generator polynomials packed into one bus
//   TABLE_ENTRIES  - (input, state) pairs swept to fill the distance table
package bm_seq_pkg;

    localparam int STATE_W       = 8;
    localparam int IN_W          = 2;
    localparam int SYM_W         = 6;
    localparam int NUM_GEN       = 6;
    localparam int GEN_W         = 10;
    localparam int TABLE_ENTRIES = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRECALC = 3'd1,
        SETTLE  = 3'd2,
        DECODE  = 3'd3,
        DONE    = 3'd4
    } bm_seq_state_t;

endpackage

// File: rtl/bm_codeword_gen.sv
// bm_codeword_gen: expected encoder codeword for one trellis branch.
//   gen      in  NUM_GEN*GEN_W  generator polynomials, poly k = gen[10k+9:10k]
//   state    in  STATE_W        encoder state
//   in_bits  in  IN_W           encoder input for this radix-4 step
//   codeword out NUM_GEN        bit k = parity of (poly k & {in_bits, state})
module bm_codeword_gen
    import bm_seq_pkg::*;
(
    input  logic [NUM_GEN*GEN_W-1:0] gen,
    input  logic [STATE_W-1:0]       state,
    input  logic [IN_W-1:0]          in_bits,
    output logic [NUM_GEN-1:0]       codeword
);

    always_comb begin
        codeword = '0;
        for (int k = 0; k < NUM_GEN; k++) begin
            codeword[k] = ^(gen[k*GEN_W +: GEN_W] & {in_bits, state});
        end
    end

endmodule

// File: rtl/bm_sequencer.sv
// bm_sequencer: sequences the radix-4 Viterbi branch-metric unit.
// First sweeps all 1024 (input, state) pairs on o_mux so the BM unit can fill
// its distance table, then streams sliced symbols to the BM/ACS path.
//   clk, rst         clock; asynchronous active-low reset
//   i_start          start pulse (IDLE only), samples i_skip_pre/i_gen/i_frame_len
//   i_sym_valid/i_sym/o_sym_ready  upstream symbol handshake
//   o_rx/o_rx_valid/i_acs_ready    downstream symbol handshake
//   o_mux            {input, state, codeword} table write to the BM unit
//   o_en_bm          BM enable (PRECALC, SETTLE, DECODE)
//   o_busy           not IDLE
//   o_pre_done       table valid since the last completed PRECALC
//   o_frame_done     one-cycle pulse at frame end
//   dbg_state        current FSM state (bm_seq_state_t encoding)
//
// Handshakes: a word moves when valid and ready are both high at a rising
// edge. Valid never waits on ready; while valid is high without ready the data
// is held unchanged. o_sym_ready = !o_rx_valid || i_acs_ready, so the output
// register may be refilled in the same cycle it is consumed.
module bm_sequencer #(
    parameter int STATE_W = 8,
    parameter int IN_W    = 2,
    parameter int SYM_W   = 6,
    parameter int LEN_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic                           i_skip_pre,
    input  logic [bm_seq_pkg::NUM_GEN*bm_seq_pkg::GEN_W-1:0] i_gen,
    input  logic [LEN_W-1:0]               i_frame_len,
    input  logic                           i_sym_valid,
    input  logic [SYM_W-1:0]               i_sym,
    output logic                           o_sym_ready,
    output logic [IN_W+STATE_W+SYM_W-1:0]  o_mux,
    output logic                           o_en_bm,
    output logic [SYM_W-1:0]               o_rx,
    output logic                           o_rx_valid,
    input  logic                           i_acs_ready,
    output logic                           o_busy,
    output logic                           o_pre_done,
    output logic                           o_frame_done,
    output logic [2:0]                     dbg_state
);

    import bm_seq_pkg::*;

    localparam int IDX_W = IN_W + STATE_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_ENTRIES - 1);

    localparam logic [2:0] S_IDLE    = IDLE;
    localparam logic [2:0] S_PRECALC = PRECALC;
    localparam logic [2:0] S_SETTLE  = SETTLE;
    localparam logic [2:0] S_DECODE  = DECODE;
    localparam logic [2:0] S_DONE    = DONE;

    logic [2:0]                   state;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             next_idx;
    logic [NUM_GEN*GEN_W-1:0]     gen_q;
    logic [NUM_GEN*GEN_W-1:0]     gen_sel;
    logic [LEN_W-1:0]             len_q;
    logic [LEN_W-1:0]             count;
    logic                         pre_done;
    logic                         rx_valid;
    logic [SYM_W-1:0]             rx;
    logic [IDX_W+SYM_W-1:0]       mux_q;
    logic [SYM_W-1:0]             cw;
    logic                         in_idle;
    logic                         frame_full;
    logic                         sym_ready;
    logic                         take;
    logic                         consume;

    // o_mux is registered, so the codeword is computed for the entry that will
    // be shown next cycle: entry 0 from the live i_gen on the start edge (the
    // latch happens on that same edge), then idx+1 from the latched copy.
    assign in_idle  = (state == S_IDLE);
    assign gen_sel  = in_idle ? i_gen : gen_q;
    assign next_idx = in_idle ? '0 : idx + 1'b1;

    bm_codeword_gen u_codeword_gen (
        .gen      (gen_sel),
        .state    (next_idx[STATE_W-1:0]),
        .in_bits  (next_idx[IDX_W-1:STATE_W]),
        .codeword (cw)
    );

    assign frame_full = (count == len_q);
    assign sym_ready  = (state == S_DECODE) && !frame_full && (!rx_valid || i_acs_ready);
    assign take       = i_sym_valid && sym_ready;
    assign consume    = rx_valid && i_acs_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            gen_q    <= '0;
            len_q    <= '0;
            count    <= '0;
            pre_done <= 1'b0;
            rx_valid <= 1'b0;
            rx       <= '0;
            mux_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        gen_q    <= i_gen;
                        len_q    <= i_frame_len;
                        count    <= '0;
                        rx_valid <= 1'b0;
                        if (i_skip_pre && pre_done) begin
                            state <= S_SETTLE;
                        end else begin
                            pre_done <= 1'b0;
                            idx      <= '0;
                            mux_q    <= {next_idx, cw};
                            state    <= S_PRECALC;
                        end
                    end
                end
                S_PRECALC: begin
                    // Last entry stays on o_mux afterwards so stray BM writes
                    // only rewrite the same value.
                    if (idx == LAST_IDX) begin
                        pre_done <= 1'b1;
                        state    <= S_SETTLE;
                    end else begin
                        idx   <= next_idx;
                        mux_q <= {next_idx, cw};
                    end
                end
                S_SETTLE: begin
                    state <= (len_q == '0) ? S_DONE : S_DECODE;
                end
                S_DECODE: begin
                    if (take) begin
                        rx       <= i_sym;
                        rx_valid <= 1'b1;
                        count    <= count + 1'b1;
                    end else if (consume) begin
                        rx_valid <= 1'b0;
                    end
                    // No transfer can coincide here: sym_ready is low once full.
                    if (frame_full && consume) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sym_ready  = sym_ready;
    assign o_mux        = mux_q;
    assign o_en_bm      = (state == S_PRECALC) || (state == S_SETTLE) || (state == S_DECODE);
    assign o_rx         = rx;
    assign o_rx_valid   = rx_valid;
    assign o_busy       = !in_idle;
    assign o_pre_done   = pre_done;
    assign o_frame_done = (state == S_DONE);
    assign dbg_state    = state;

endmodule
